// File: rtl/code_prefetch_if.sv
// ============================================================================
// Module      : code_prefetch_if
// Description : Core-side code address/data bus plus the code-memory request
//               bus of the instruction prefetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface code_prefetch_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_data_already;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Prefetcher side
    modport slave (
        input  cpu_addr,
        input  mem_ready,
        input  mem_rdata,
        output cpu_data,
        output cpu_data_already,
        output mem_req,
        output mem_addr
    );

    // Core + code memory side
    modport master (
        output cpu_addr,
        output mem_ready,
        output mem_rdata,
        input  cpu_data,
        input  cpu_data_already,
        input  mem_req,
        input  mem_addr
    );
endinterface

`default_nettype wire

// File: rtl/code_prefetch.sv
// ============================================================================
// Module      : code_prefetch
// Description : Sequential instruction prefetch queue between core and code
//               memory. Optional same-cycle bypass: CODE_PREFETCH_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    code_prefetch_if.slave      cp_bus
);

    localparam int unsigned            c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]       c_DEPTH = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]       c_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0]     c_PINC  = c_PTR_W'(1);

    logic [31:0]        addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_PTR_W:0]   count_q, count_d;
    logic [31:0]        pc_q, pc_d;

    logic [31:0]        w_cpu_aligned;
    logic [c_PTR_W-1:0] w_head1;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_pend;
    logic               w_miss;
    logic               w_complete;
    logic               w_push;
    logic               w_pop;

    // Byte offset is irrelevant for word matching; pc_q low bits stay zero.
    assign w_cpu_aligned = cp_bus.cpu_addr & 32'hFFFF_FFFC;
    assign w_head1       = head_q + c_PINC;

    assign w_hit0 = (count_q != '0) && (w_cpu_aligned == addr_q[head_q]);
    assign w_hit1 = !w_hit0 && (count_q > c_ONE) && (w_cpu_aligned == addr_q[w_head1]);
    assign w_pend = !w_hit0 && !w_hit1 && (count_q == '0) && (w_cpu_aligned == pc_q);
    assign w_miss = !w_hit0 && !w_hit1 && !w_pend;

    assign cp_bus.mem_req  = (count_q < c_DEPTH);
    assign cp_bus.mem_addr = pc_q;

    assign w_complete = cp_bus.mem_req && cp_bus.mem_ready;
    assign w_push     = w_complete && !w_miss;
    assign w_pop      = w_hit1;

    always_comb begin
        cp_bus.cpu_data_already = 1'b0;
        cp_bus.cpu_data         = 32'h0;
        if (w_hit0) begin
            cp_bus.cpu_data_already = 1'b1;
            cp_bus.cpu_data         = data_q[head_q];
        end else if (w_hit1) begin
            cp_bus.cpu_data_already = 1'b1;
            cp_bus.cpu_data         = data_q[w_head1];
        end
`ifdef CODE_PREFETCH_BYPASS_EN
        else if (w_pend && w_complete) begin
            cp_bus.cpu_data_already = 1'b1;
            cp_bus.cpu_data         = cp_bus.mem_rdata;
        end
`endif
    end

    // A miss flushes the queue and redirects; its completion is dropped.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        if (w_miss) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = w_cpu_aligned;
        end else begin
            if (w_push) begin
                tail_d = tail_q + c_PINC;
                pc_d   = pc_q + 32'd4;
            end
            if (w_pop) begin
                head_d = w_head1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_ONE;
                2'b01:   count_d = count_q - c_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[tail_q] <= pc_q;
            data_q[tail_q] <= cp_bus.mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_prefetch.sv
// ============================================================================
// Module      : tb_code_prefetch
// Description : Directed table-driven bench for code_prefetch (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_prefetch;

    localparam logic [31:0] c_KEY = 32'hC0DE_5A5A;
`ifdef CODE_PREFETCH_BYPASS_EN
    localparam logic c_BYP = 1'b1;
`else
    localparam logic c_BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rdy;
        logic        valid;
        logic [31:0] data;
        logic        req;
        logic [31:0] maddr;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    code_prefetch_if bus ();

    code_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .cp_bus (bus)
    );

    // Memory image: each word is its own address XOR a key.
    assign bus.mem_rdata = bus.mem_addr ^ c_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dval(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) ^ c_KEY;
    endfunction

    function automatic void add(input logic [31:0] a, input logic r, input logic v,
                                input logic q, input logic [31:0] m);
        vec_t t;
        t.addr  = a;
        t.rdy   = r;
        t.valid = v;
        t.data  = v ? dval(a) : 32'h0;
        t.req   = q;
        t.maddr = m;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [31:0] d,
                            input logic q, input logic [31:0] m);
        chk({tag, " valid"}, {31'h0, bus.cpu_data_already}, {31'h0, v});
        chk({tag, " data"},  bus.cpu_data, d);
        chk({tag, " req"},   {31'h0, bus.mem_req}, {31'h0, q});
        chk({tag, " maddr"}, bus.mem_addr, m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Sequential stream from reset, steady HIT1 flow
        add(32'h0, 1'b1, c_BYP, 1'b1, 32'h0);
        add(32'h0, 1'b1, 1'b1,  1'b1, 32'h4);
        for (int n = 3; n <= 17; n++)
            add(32'(4 * (n - 2)), 1'b1, 1'b1, 1'b1, 32'(4 * (n - 1)));
        // Hold: queue fills, request drops
        add(32'h3C, 1'b1, 1'b1, 1'b1, 32'h44);
        add(32'h3C, 1'b1, 1'b1, 1'b1, 32'h48);
        add(32'h3C, 1'b1, 1'b1, 1'b0, 32'h4C);
        add(32'h3C, 1'b1, 1'b1, 1'b0, 32'h4C);
        // Full-queue pop, memory stalls, then push+pop
        add(32'h40, 1'b0, 1'b1, 1'b0, 32'h4C);
        add(32'h40, 1'b0, 1'b1, 1'b1, 32'h4C);
        add(32'h40, 1'b0, 1'b1, 1'b1, 32'h4C);
        add(32'h40, 1'b0, 1'b1, 1'b1, 32'h4C);
        add(32'h44, 1'b1, 1'b1, 1'b1, 32'h4C);
        add(32'h44, 1'b1, 1'b1, 1'b1, 32'h50);
        add(32'h44, 1'b1, 1'b1, 1'b0, 32'h54);
        add(32'h47, 1'b0, 1'b1, 1'b0, 32'h54);
        add(32'h48, 1'b0, 1'b1, 1'b0, 32'h54);
        // Redirect with a completion that must be dropped
        add(32'h200, 1'b1, 1'b0,  1'b1, 32'h54);
        add(32'h200, 1'b0, 1'b0,  1'b1, 32'h200);
        add(32'h200, 1'b1, c_BYP, 1'b1, 32'h200);
        add(32'h200, 1'b1, 1'b1,  1'b1, 32'h204);
        // Address wrap at top of the space
        add(32'hFFFF_FFF8, 1'b0, 1'b0,  1'b1, 32'h208);
        add(32'hFFFF_FFF8, 1'b1, c_BYP, 1'b1, 32'hFFFF_FFF8);
        add(32'hFFFF_FFF8, 1'b1, 1'b1,  1'b1, 32'hFFFF_FFFC);
        add(32'hFFFF_FFFC, 1'b1, 1'b1,  1'b1, 32'h0);
        add(32'h0,         1'b1, 1'b1,  1'b1, 32'h4);

        reset         = 1'b1;
        bus.cpu_addr  = 32'h0;
        bus.mem_ready = 1'b0;
        #1;
        chk_outs("reset", 1'b0, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.cpu_addr  = vecs[i].addr;
            bus.mem_ready = vecs[i].rdy;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data,
                     vecs[i].req, vecs[i].maddr);
        end

        // Asynchronous reset between edges flushes a live queue at once
        @(negedge clk);
        bus.cpu_addr  = 32'h4;
        bus.mem_ready = 1'b0;
        #1;
        chk_outs("pre_areset", 1'b1, dval(32'h4), 1'b1, 32'h8);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("areset", 1'b0, 32'h0, 1'b1, 32'h0);

        // From reset, address held at 0: four completions then stall at 0x10
        @(negedge clk);
        reset         = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk_outs($sformatf("fill%0d", i), (i == 0) ? c_BYP : 1'b1,
                     ((i == 0) && !c_BYP) ? 32'h0 : dval(32'h0),
                     (i < 4), (i < 4) ? 32'(4 * i) : 32'h10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
